// File: rtl/sevenseg_pkg.sv
// Shared register map, segment type and hex decode table for the seven-segment controller.
package sevenseg_pkg;

    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned SEG_W      = 7;

    localparam logic [ADDR_W-1:0] REG_DIGIT0   = 5'h00;
    localparam logic [ADDR_W-1:0] REG_EN_LO    = 5'h10;
    localparam logic [ADDR_W-1:0] REG_EN_HI    = 5'h11;
    localparam logic [ADDR_W-1:0] REG_BLINK_LO = 5'h12;
    localparam logic [ADDR_W-1:0] REG_BLINK_HI = 5'h13;
    localparam logic [ADDR_W-1:0] REG_RAW_LO   = 5'h14;
    localparam logic [ADDR_W-1:0] REG_RAW_HI   = 5'h15;
    localparam logic [ADDR_W-1:0] REG_BRIGHT   = 5'h16;
    localparam logic [ADDR_W-1:0] REG_CTRL     = 5'h17;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t BLANK = 7'h7F;

    // Active-high hex glyphs, bit 0 = segment a.
    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 4-bit hex to active-high segment decoder.
module seven_seg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg_c
);

    assign seg_c = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_ctrl.sv
// Bus-mapped multi-digit seven-segment controller with per-digit enable, blink and raw mode.
// Optional PWM brightness dimming is built when SEVENSEG_PWM_EN is defined.
module seven_seg_ctrl
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLINK_W    = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs,
    input  logic                        rw,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           data_in,
    output logic [DATA_W-1:0]           data_out,
    output logic [SEG_W*NUM_DIGITS-1:0] seg_n
);

    localparam logic [MAX_DIGITS-1:0] DIG_MASK = MAX_DIGITS'((33'd1 << NUM_DIGITS) - 33'd1);

    logic [DATA_W-1:0]     digit [MAX_DIGITS];
    logic [MAX_DIGITS-1:0] en;
    logic [MAX_DIGITS-1:0] blink;
    logic [MAX_DIGITS-1:0] raw;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blink_phase_c;
    logic                  pwm_on_c;
    logic                  wr_c;
    logic                  rd_c;
    logic                  digit_hit_c;
    logic [DATA_W-1:0]     rd_data_c;
    seg_t                  hex_seg_c [NUM_DIGITS];
    seg_t                  disp_c    [NUM_DIGITS];
    seg_t                  disp_q    [NUM_DIGITS];

    assign wr_c          = cs & ~rw;
    assign rd_c          = cs & rw;
    assign digit_hit_c   = ~addr[4] && (32'(addr[3:0]) < NUM_DIGITS);
    assign blink_phase_c = blink_cnt[BLINK_W-1];

    // Configuration registers; mask bits beyond NUM_DIGITS are never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(MAX_DIGITS); k++) digit[k] <= '0;
            en    <= '0;
            blink <= '0;
            raw   <= '0;
        end else if (wr_c) begin
            if (digit_hit_c) digit[addr[3:0]] <= data_in;
            case (addr)
                REG_EN_LO:    en[7:0]     <= data_in & DIG_MASK[7:0];
                REG_EN_HI:    en[15:8]    <= data_in & DIG_MASK[15:8];
                REG_BLINK_LO: blink[7:0]  <= data_in & DIG_MASK[7:0];
                REG_BLINK_HI: blink[15:8] <= data_in & DIG_MASK[15:8];
                REG_RAW_LO:   raw[7:0]    <= data_in & DIG_MASK[7:0];
                REG_RAW_HI:   raw[15:8]   <= data_in & DIG_MASK[15:8];
                default: ;
            endcase
        end
    end

    // Free-running blink prescaler; a CTRL bit0 write restarts it in the lit phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (wr_c && addr == REG_CTRL && data_in[0]) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

`ifdef SEVENSEG_PWM_EN
    logic [3:0] bright;
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright  <= 4'hF;
            pwm_cnt <= 4'h0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (wr_c && addr == REG_BRIGHT) bright <= data_in[3:0];
        end
    end

    assign pwm_on_c = (pwm_cnt <= bright);
`else
    assign pwm_on_c = 1'b1;
`endif

    always_comb begin
        rd_data_c = '0;
        if (digit_hit_c) rd_data_c = digit[addr[3:0]];
        case (addr)
            REG_EN_LO:    rd_data_c = en[7:0];
            REG_EN_HI:    rd_data_c = en[15:8];
            REG_BLINK_LO: rd_data_c = blink[7:0];
            REG_BLINK_HI: rd_data_c = blink[15:8];
            REG_RAW_LO:   rd_data_c = raw[7:0];
            REG_RAW_HI:   rd_data_c = raw[15:8];
`ifdef SEVENSEG_PWM_EN
            REG_BRIGHT:   rd_data_c = {4'h0, bright};
`endif
            REG_CTRL:     rd_data_c = {6'b0, blink_phase_c, 1'b0};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_out <= '0;
        else if (rd_c) data_out <= rd_data_c;
    end

    for (genvar k = 0; k < int'(NUM_DIGITS); k++) begin : g_dec
        seven_seg_decode u_dec (
            .nibble (digit[k][3:0]),
            .seg_c  (hex_seg_c[k])
        );
    end

    always_comb begin
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            disp_c[k] = '0;
            if (en[k] && !(blink[k] && blink_phase_c) && pwm_on_c)
                disp_c[k] = raw[k] ? digit[k][6:0] : hex_seg_c[k];
        end
    end

    // Two register stages give a fixed write-to-pin latency; inversion at the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NUM_DIGITS); k++) disp_q[k] <= '0;
            seg_n <= {NUM_DIGITS{BLANK}};
        end else begin
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                disp_q[k]          <= disp_c[k];
                seg_n[7*k +: 7]    <= ~disp_q[k];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Self-checking bench for seven_seg_ctrl (NUM_DIGITS=6, BLINK_W=4) with a read-data scoreboard.
module tb_seven_seg_ctrl;

    localparam int unsigned ND = 6;
    localparam int unsigned BW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cs;
    logic            rw;
    logic [4:0]      addr;
    logic [7:0]      data_in;
    logic [7:0]      data_out;
    logic [7*ND-1:0] seg_n;

    int total = 0;
    int bad   = 0;
    logic [7:0] rd_q [$];

    always #5 clk = ~clk;

    seven_seg_ctrl #(.NUM_DIGITS(ND), .BLINK_W(BW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .seg_n    (seg_n)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
        @(negedge clk);
        cs = 1'b0;
    endtask

    // Queues the expected read data and performs the read edge.
    task automatic issue_read(input logic [4:0] a, input logic [7:0] exp);
        cs = 1'b1; rw = 1'b1; addr = a;
        rd_q.push_back(exp);
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] e;
        rst_n = 1'b0; cs = 1'b0; rw = 1'b0; addr = '0; data_in = '0;
        wait_cyc(2);
        total++;
        if (seg_n !== {ND{7'h7F}}) begin bad++; $display("FAIL reset_seg: got %h want %h", seg_n, {ND{7'h7F}}); end
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", data_out); end
        rst_n = 1'b1;
        wait_cyc(1);
`ifdef SEVENSEG_PWM_EN
        issue_read(5'h16, 8'h0F);
`else
        issue_read(5'h16, 8'h00);
`endif
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL reset_bright: got %h want %h", data_out, e); end
        issue_read(5'h10, 8'h00);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL reset_en: got %h want %h", data_out, e); end
    endtask

    task automatic test_hex;
        logic [6:0] exp;
        do_write(5'h10, 8'h01);
        for (int v = 0; v < 16; v++) begin
            do_write(5'h00, 8'(v));
            wait_cyc(2);
            exp = ~hex7(4'(v));
            total++;
            if (seg_n[6:0] !== exp) begin bad++; $display("FAIL hex_%0d: got %h want %h", v, seg_n[6:0], exp); end
        end
        do_write(5'h00, 8'h05);
        wait_cyc(2);
        total++;
        if (seg_n !== {{5{7'h7F}}, 7'h12}) begin bad++; $display("FAIL hex_5_all: got %h want %h", seg_n, {{5{7'h7F}}, 7'h12}); end
    endtask

    task automatic test_raw_and_mask;
        logic [7:0] e;
        do_write(5'h14, 8'h02);
        do_write(5'h01, 8'h49);
        do_write(5'h10, 8'h03);
        wait_cyc(2);
        total++;
        if (seg_n[13:7] !== 7'h36) begin bad++; $display("FAIL raw_seg: got %h want 36", seg_n[13:7]); end
        issue_read(5'h01, 8'h49);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL rd_digit1: got %h want %h", data_out, e); end
        issue_read(5'h14, 8'h02);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL rd_raw: got %h want %h", data_out, e); end
        do_write(5'h10, 8'hFF);
        issue_read(5'h10, 8'h3F);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL en_mask_lo: got %h want %h", data_out, e); end
        wait_cyc(1);
        total++;
        if (seg_n !== {{4{7'h40}}, 7'h36, 7'h12}) begin bad++; $display("FAIL all_on: got %h want %h", seg_n, {{4{7'h40}}, 7'h36, 7'h12}); end
        do_write(5'h11, 8'hFF);
        issue_read(5'h11, 8'h00);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL en_mask_hi: got %h want %h", data_out, e); end
        do_write(5'h10, 8'h03);
    endtask

    task automatic test_unmapped;
        logic [7:0] e;
        do_write(5'h1F, 8'hAA);
        do_write(5'h06, 8'hAA);
        issue_read(5'h1F, 8'h00);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL rd_1f: got %h want %h", data_out, e); end
        issue_read(5'h06, 8'h00);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL rd_digit6: got %h want %h", data_out, e); end
        wait_cyc(2);
        total++;
        if (seg_n !== {{4{7'h7F}}, 7'h36, 7'h12}) begin bad++; $display("FAIL unmapped_seg: got %h want %h", seg_n, {{4{7'h7F}}, 7'h36, 7'h12}); end
    endtask

    task automatic test_blink;
        logic [7:0] e;
        logic [6:0] s;
        do_write(5'h00, 8'h08);
        do_write(5'h12, 8'h01);
        issue_read(5'h12, 8'h01);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL rd_blink: got %h want %h", data_out, e); end
        do_write(5'h17, 8'h01);
        // Counter is 0 after the clear edge; stream CTRL reads and watch digit 0.
        cs = 1'b1; rw = 1'b1; addr = 5'h17;
        rd_q.push_back(8'h00);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            e = rd_q.pop_front(); total++;
            if (data_out !== e) begin bad++; $display("FAIL ctrl_phase_%0d: got %h want %h", j, data_out, e); end
            if (j >= 2) begin
                s = (((j - 2) % 16) < 8) ? 7'h00 : 7'h7F;
                total++;
                if (seg_n[6:0] !== s) begin bad++; $display("FAIL blink_%0d: got %h want %h", j, seg_n[6:0], s); end
            end
            if (j < 40) rd_q.push_back(((j % 16) >= 8) ? 8'h02 : 8'h00);
            else cs = 1'b0;
        end
        do_write(5'h17, 8'h01);
        wait_cyc(1);
        total++;
        if (seg_n[6:0] !== 7'h7F) begin bad++; $display("FAIL restart_pre: got %h want 7f", seg_n[6:0]); end
        wait_cyc(1);
        total++;
        if (seg_n[6:0] !== 7'h00) begin bad++; $display("FAIL restart_lit: got %h want 00", seg_n[6:0]); end
        do_write(5'h12, 8'h00);
    endtask

    task automatic test_pwm;
        logic [7:0] e;
        int lit;
        int want;
        do_write(5'h16, 8'h03);
`ifdef SEVENSEG_PWM_EN
        issue_read(5'h16, 8'h03);
        want = 4;
`else
        issue_read(5'h16, 8'h00);
        want = 16;
`endif
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL rd_bright: got %h want %h", data_out, e); end
        wait_cyc(3);
        for (int w = 0; w < 2; w++) begin
            lit = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (seg_n[6:0] === 7'h00) lit++;
            end
            total++;
            if (lit != want) begin bad++; $display("FAIL pwm_window_%0d: got %0d lit want %0d", w, lit, want); end
        end
        do_write(5'h16, 8'h0F);
    endtask

    task automatic test_async_reset;
        logic [7:0] e;
        do_write(5'h12, 8'h01);
        wait_cyc(3);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (seg_n !== {ND{7'h7F}}) begin bad++; $display("FAIL async_seg: got %h want %h", seg_n, {ND{7'h7F}}); end
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL async_dout: got %h want 00", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        issue_read(5'h12, 8'h00);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL post_rst_blink: got %h want %h", data_out, e); end
        issue_read(5'h01, 8'h00);
        e = rd_q.pop_front(); total++;
        if (data_out !== e) begin bad++; $display("FAIL post_rst_digit1: got %h want %h", data_out, e); end
        total++;
        if (seg_n !== {ND{7'h7F}}) begin bad++; $display("FAIL post_rst_seg: got %h want %h", seg_n, {ND{7'h7F}}); end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_raw_and_mask();
        test_unmapped();
        test_blink();
        test_pwm();
        test_async_reset();
        if (rd_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
